vdp_cpu_port: RTL and testbench
===============================

# vdp_cpu_port

CPU-side access port of the VDP: the writer (and optional reader) of the 64 KB video RAM whose display side is read by the VDP scan-out logic. Accepts byte-wide CPU accesses on a control port and a data port, maintains an auto-incrementing 16-bit VRAM pointer, and performs VRAM cycles only in slots granted by the VDP display arbiter. Sits between the CPU bus decode and the VRAM address/data mux inside the VDP.

## Interface
- No parameters; VRAM address width fixed at 16, data width at 8.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpuSelect  in  1  one-cycle access strobe
- cpuWrite  in  1  1 = write, 0 = read; sampled with cpuSelect
- cpuMode  in  1  0 = data port, 1 = control port
- cpuDataIn  in  8  CPU write data
- cpuDataOut  out  8  CPU read data, registered
- cpuBusy  out  1  high while a VRAM cycle is pending
- vramRequest  out  1  port wants the VRAM this cycle
- vramGrant  in  1  display arbiter grants the VRAM this cycle
- vramAddress  out  16  VRAM address
- vramWriteEnabled  out  1  VRAM write strobe
- vramDataWrite  out  8  VRAM write data
- vramDataRead  in  8  VRAM read data, valid one cycle after address

## Operation
- State machine: IDLE, WRITE (waiting grant), READ_REQ (waiting grant), READ_DATA (capture).
- Control write, toggle=0: address[7:0] <= cpuDataIn, toggle <= 1. Toggle=1: address[15:8] <= cpuDataIn, toggle <= 0; with read path, enter READ_REQ (prefetch).
- Control read: cpuDataOut <= {busy, toggle, overrun, 5'b0}; toggle <= 0, overrun <= 0. Always serviced, any state.
- Data write (IDLE): writeBuffer <= cpuDataIn, toggle <= 0, go WRITE.
- Data read (IDLE): cpuDataOut <= readBuffer, toggle <= 0, go READ_REQ.
- WRITE: vramRequest=1; on vramGrant, vramWriteEnabled=1, vramAddress=address, vramDataWrite=writeBuffer; address increments, go IDLE.
- READ_REQ: vramRequest=1; on vramGrant, vramAddress=address, go READ_DATA. READ_DATA: readBuffer <= vramDataRead, address increments, go IDLE.
- Address increment is modulo 2^16: 0xFFFF -> 0x0000.
- Any access other than control read while state != IDLE: ignored, overrun <= 1.
- cpuBusy = (state != IDLE). vramRequest low in IDLE and READ_DATA.
- vramAddress holds last driven value when not requesting; vramWriteEnabled only ever high in WRITE with grant.

## Timing
- Reset: state IDLE, address 0x0000, toggle 0, overrun 0, writeBuffer 0x00, readBuffer 0x00, cpuDataOut 0x00, cpuBusy 0, vramRequest 0, vramWriteEnabled 0, vramAddress 0x0000, vramDataWrite 0x00.
- Reset has priority over every strobe; reset mid-cycle abandons any pending access with no VRAM write.
- Data write at cycle N -> earliest VRAM write cycle N+1 (grant high); cpuBusy high N+1 until grant cycle inclusive.
- Data read at cycle N: cpuDataOut valid N+1 (old buffer); prefetch address cycle >= N+1, readBuffer updated one cycle after grant.
- Grant low indefinitely: state holds, no timeout.
- cpuDataOut changes only on CPU reads.

## Configuration
- VDP_CPU_READ_EN defined: read-ahead path present (READ_REQ/READ_DATA, readBuffer, prefetch on second control byte).
- Undefined: data-port reads return 0xFF, no state change, no VRAM cycle; second control byte returns to IDLE directly; read states and readBuffer absent.

## Structure
- Shared package vdp_pkg: state encodings, port-select constants (DATA=0, CONTROL=1), status bit positions (BUSY=7, TOGGLE=6, OVERRUN=5), VRAM width constants.
- Single module, no sub-module; VRAM mux/arbiter lives in the VDP top.

## Test plan
- Control 0x34 then 0x12, data write 0xAB, grant held high -> one vramWriteEnabled pulse at 0x1234 with 0xAB; address becomes 0x1235.
- Address 0xFFFF, two data writes 0x01/0x02 -> VRAM writes at 0xFFFF then 0x0000.
- Grant low 10 cycles after data write, second data write during wait -> cpuBusy high throughout, second write dropped, status read returns bit5=1 then 0 on next read.
- VDP_CPU_READ_EN: VRAM[0x2000]=0x55, [0x2001]=0x66; set address 0x2000, two data reads -> 0x55, 0x66.
- Control 0x34 only, then status read, then control 0x00, 0x40 -> address 0x4000 (toggle reset by status read).
- Reset asserted during WRITE awaiting grant -> no write strobe, all outputs at reset values next cycle.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared VDP definitions: CPU-port FSM states, port selects, status bit
// positions and VRAM widths.
package vdp_pkg;

  localparam int VRAM_ADDR_W = 16;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_REQ  = 2'd2,
    READ_DATA = 2'd3
  } vdpState_t;

  localparam logic PORT_DATA    = 1'b0;
  localparam logic PORT_CONTROL = 1'b1;

  localparam int STATUS_BUSY    = 7;
  localparam int STATUS_TOGGLE  = 6;
  localparam int STATUS_OVERRUN = 5;

  function automatic logic [VRAM_DATA_W-1:0] statusByte(input logic busy,
                                                         input logic toggleBit,
                                                         input logic overrunBit);
    logic [VRAM_DATA_W-1:0] s;
    s = '0;
    s[STATUS_BUSY]    = busy;
    s[STATUS_TOGGLE]  = toggleBit;
    s[STATUS_OVERRUN] = overrunBit;
    return s;
  endfunction

endpackage

// File: rtl/vdp_cpu_port.sv
// CPU access port of the VDP: byte-wide control/data ports, auto-incrementing
// VRAM pointer, arbiter-granted VRAM cycles. Read-ahead path under VDP_CPU_READ_EN.
module vdp_cpu_port
  import vdp_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpuSelect,
  input  logic                   cpuWrite,
  input  logic                   cpuMode,
  input  logic [VRAM_DATA_W-1:0] cpuDataIn,
  output logic [VRAM_DATA_W-1:0] cpuDataOut,
  output logic                   cpuBusy,
  output logic                   vramRequest,
  input  logic                   vramGrant,
  output logic [VRAM_ADDR_W-1:0] vramAddress,
  output logic                   vramWriteEnabled,
  output logic [VRAM_DATA_W-1:0] vramDataWrite,
  input  logic [VRAM_DATA_W-1:0] vramDataRead
);

  vdpState_t              state, stateNext;
  logic [VRAM_ADDR_W-1:0] address;
  logic [VRAM_ADDR_W-1:0] addressHold;
  logic                   toggle;
  logic                   overrun;
  logic [VRAM_DATA_W-1:0] writeBuffer;
`ifdef VDP_CPU_READ_EN
  logic [VRAM_DATA_W-1:0] readBuffer;
`else
  logic                   unusedRead;
  assign unusedRead = ^vramDataRead;
`endif

  logic controlRead, accepted, controlWrite, dataWrite, dataRead;

  // Status reads are serviced in every state; all other accesses need IDLE.
  assign controlRead  = cpuSelect && !cpuWrite && (cpuMode == PORT_CONTROL);
  assign accepted     = cpuSelect && !controlRead && (state == IDLE);
  assign controlWrite = accepted && cpuWrite && (cpuMode == PORT_CONTROL);
  assign dataWrite    = accepted && cpuWrite && (cpuMode == PORT_DATA);
  assign dataRead     = accepted && !cpuWrite && (cpuMode == PORT_DATA);

  assign cpuBusy       = (state != IDLE);
  assign vramDataWrite = writeBuffer;

  always_comb begin
    stateNext        = state;
    vramRequest      = 1'b0;
    vramWriteEnabled = 1'b0;
    vramAddress      = addressHold;
    case (state)
      IDLE: begin
        if (dataWrite) stateNext = WRITE;
`ifdef VDP_CPU_READ_EN
        if (dataRead || (controlWrite && toggle)) stateNext = READ_REQ;
`endif
      end
      WRITE: begin
        vramRequest = 1'b1;
        vramAddress = address;
        if (vramGrant) begin
          vramWriteEnabled = 1'b1;
          stateNext        = IDLE;
        end
      end
`ifdef VDP_CPU_READ_EN
      READ_REQ: begin
        vramRequest = 1'b1;
        vramAddress = address;
        if (vramGrant) stateNext = READ_DATA;
      end
      READ_DATA: stateNext = IDLE;
`endif
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      address     <= '0;
      addressHold <= '0;
      toggle      <= 1'b0;
      overrun     <= 1'b0;
      writeBuffer <= '0;
      cpuDataOut  <= '0;
`ifdef VDP_CPU_READ_EN
      readBuffer  <= '0;
`endif
    end else begin
      state <= stateNext;
      // The VRAM address output keeps the last value driven while requesting.
      if (vramRequest) addressHold <= address;

      if (controlRead) begin
        cpuDataOut <= statusByte(cpuBusy, toggle, overrun);
        toggle     <= 1'b0;
        overrun    <= 1'b0;
      end else if (cpuSelect && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      if (controlWrite) begin
        if (!toggle) begin
          address[7:0] <= cpuDataIn;
          toggle       <= 1'b1;
        end else begin
          address[15:8] <= cpuDataIn;
          toggle        <= 1'b0;
        end
      end

      if (dataWrite) begin
        writeBuffer <= cpuDataIn;
        toggle      <= 1'b0;
      end

      if (dataRead) begin
`ifdef VDP_CPU_READ_EN
        cpuDataOut <= readBuffer;
`else
        cpuDataOut <= 8'hFF;
`endif
        toggle     <= 1'b0;
      end

      if ((state == WRITE) && vramGrant) address <= address + 16'd1;
`ifdef VDP_CPU_READ_EN
      if (state == READ_DATA) begin
        readBuffer <= vramDataRead;
        address    <= address + 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Self-checking bench for vdp_cpu_port: VRAM model, write scoreboard,
// table-driven write vectors and hand-written corner sequences.
module tb_vdp_cpu_port;

  logic        clk;
  logic        reset;
  logic        cpuSelect;
  logic        cpuWrite;
  logic        cpuMode;
  logic [7:0]  cpuDataIn;
  logic [7:0]  cpuDataOut;
  logic        cpuBusy;
  logic        vramRequest;
  logic        vramGrant;
  logic [15:0] vramAddress;
  logic        vramWriteEnabled;
  logic [7:0]  vramDataWrite;
  logic [7:0]  vramDataRead;

  // Second control byte triggers a prefetch that advances the pointer.
`ifdef VDP_CPU_READ_EN
  localparam logic [15:0] PREFETCH_INC = 16'd1;
`else
  localparam logic [15:0] PREFETCH_INC = 16'd0;
`endif

  int passed = 0;
  int total  = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_exp;
  logic [7:0]  vram_mem [65536];

  vdp_cpu_port dut (
    .clk              (clk),
    .reset            (reset),
    .cpuSelect        (cpuSelect),
    .cpuWrite         (cpuWrite),
    .cpuMode          (cpuMode),
    .cpuDataIn        (cpuDataIn),
    .cpuDataOut       (cpuDataOut),
    .cpuBusy          (cpuBusy),
    .vramRequest      (vramRequest),
    .vramGrant        (vramGrant),
    .vramAddress      (vramAddress),
    .vramWriteEnabled (vramWriteEnabled),
    .vramDataWrite    (vramDataWrite),
    .vramDataRead     (vramDataRead)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: read data is valid one cycle after the address.
  always @(posedge clk) begin
    vramDataRead <= vram_mem[vramAddress];
    if (vramWriteEnabled) vram_mem[vramAddress] <= vramDataWrite;
  end

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Scoreboard: every VRAM write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (vramWriteEnabled) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got write %h at %h, required no write",
                 vramDataWrite, vramAddress);
      end else begin
        mon_exp = exp_q.pop_front();
        check("vram_write", {vramAddress, vramDataWrite}, mon_exp);
      end
    end
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic mode, input logic wr, input logic [7:0] d);
    cpuSelect = 1'b1;
    cpuMode   = mode;
    cpuWrite  = wr;
    cpuDataIn = d;
    tick();
    cpuSelect = 1'b0;
    cpuWrite  = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (cpuBusy && n < 50) begin
      tick();
      n++;
    end
    check("idle_timeout", 24'(cpuBusy), 24'(0));
  endtask

  task automatic set_address(input logic [15:0] a);
    access(1'b1, 1'b1, a[7:0]);
    access(1'b1, 1'b1, a[15:8]);
    if (cpuBusy) begin
      vramGrant = 1'b1;
      wait_idle();
      vramGrant = 1'b0;
    end
  endtask

  task automatic status_read(input string name, input logic [7:0] exp);
    access(1'b1, 1'b0, 8'h00);
    check(name, 24'(cpuDataOut), 24'(exp));
  endtask

  task automatic data_write(input logic [15:0] expAddr, input logic [7:0] d);
    exp_q.push_back({expAddr, d});
    access(1'b0, 1'b1, d);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          delay;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'h0000, 8'h11, 0};
    vecs[1] = '{16'h8000, 8'h5A, 3};
    vecs[2] = '{16'h00FF, 8'hA5, 1};
    vecs[3] = '{16'hFFF0, 8'h3C, 5};
    vecs[4] = '{16'h7FFF, 8'hC3, $urandom_range(2, 6)};

    reset = 1'b1; cpuSelect = 1'b0; cpuWrite = 1'b0; cpuMode = 1'b0;
    cpuDataIn = 8'h00; vramGrant = 1'b0;
    vram_mem[16'h2000] = 8'h55;
    vram_mem[16'h2001] = 8'h66;
    repeat (3) tick();

    // Reset values
    check("rst_dataout", 24'(cpuDataOut), 24'h00);
    check("rst_busy", 24'(cpuBusy), 24'(0));
    check("rst_req", 24'(vramRequest), 24'(0));
    check("rst_we", 24'(vramWriteEnabled), 24'(0));
    check("rst_addr", 24'(vramAddress), 24'h0000);
    check("rst_wdata", 24'(vramDataWrite), 24'h00);
    reset = 1'b0;
    tick();
    status_read("rst_status", 8'h00);

    // Address 0x1234, write 0xAB with grant held high
    vramGrant = 1'b1;
    set_address(16'h1234);
    vramGrant = 1'b1;
    data_write(16'h1234 + PREFETCH_INC, 8'hAB);
    check("w1_busy", 24'(cpuBusy), 24'(1));
    check("w1_we", 24'(vramWriteEnabled), 24'(1));
    check("w1_addr", 24'(vramAddress), 24'(16'h1234 + PREFETCH_INC));
    tick();
    check("w1_done", 24'(cpuBusy), 24'(0));
    data_write(16'h1235 + PREFETCH_INC, 8'hCD);
    wait_idle();
    vramGrant = 1'b0;

    // Table-driven writes with varying grant delay
    for (int i = 0; i < 5; i++) begin
      logic [15:0] ea;
      ea = vecs[i].addr + PREFETCH_INC;
      vramGrant = 1'b0;
      set_address(vecs[i].addr);
      data_write(ea, vecs[i].data);
      for (int k = 0; k < vecs[i].delay; k++) tick();
      check("vec_pending", 24'({cpuBusy, vramRequest}), 24'(2'b11));
      vramGrant = 1'b1;
      wait_idle();
      vramGrant = 1'b0;
      check("vec_addr_hold", 24'(vramAddress), 24'(ea));
      check("vec_req_idle", 24'(vramRequest), 24'(0));
      check("vec_mem", 24'(vram_mem[ea]), 24'(vecs[i].data));
      status_read("vec_status", 8'h00);
    end

    // Pointer wrap 0xFFFF -> 0x0000
    set_address(16'hFFFF - PREFETCH_INC);
    vramGrant = 1'b1;
    data_write(16'hFFFF, 8'h01);
    wait_idle();
    data_write(16'h0000, 8'h02);
    wait_idle();
    vramGrant = 1'b0;
    check("wrap_mem_ffff", 24'(vram_mem[16'hFFFF]), 24'h01);
    check("wrap_mem_0000", 24'(vram_mem[16'h0000]), 24'h02);

    // Overrun: second write during a stalled cycle is dropped
    set_address(16'h0100);
    data_write(16'h0100 + PREFETCH_INC, 8'h77);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) access(1'b0, 1'b1, 8'h88);
      else tick();
      check("ovr_busy", 24'(cpuBusy), 24'(1));
    end
    check("ovr_dataout_hold", 24'(cpuDataOut), 24'h00);
    vramGrant = 1'b1;
    wait_idle();
    vramGrant = 1'b0;
    status_read("ovr_status1", 8'h20);
    status_read("ovr_status2", 8'h00);
    check("ovr_mem", 24'(vram_mem[16'h0100 + PREFETCH_INC]), 24'h77);

    // Status read clears the byte toggle
    access(1'b1, 1'b1, 8'h34);
    status_read("tgl_status", 8'h40);
    set_address(16'h4000);
    vramGrant = 1'b1;
    data_write(16'h4000 + PREFETCH_INC, 8'h99);
    wait_idle();
    vramGrant = 1'b0;

`ifdef VDP_CPU_READ_EN
    // Read-ahead: first read returns the prefetched byte
    set_address(16'h2000);
    access(1'b0, 1'b0, 8'h00);
    check("rd_first", 24'(cpuDataOut), 24'h55);
    vramGrant = 1'b1;
    wait_idle();
    vramGrant = 1'b0;
    access(1'b0, 1'b0, 8'h00);
    check("rd_second", 24'(cpuDataOut), 24'h66);
    vramGrant = 1'b1;
    wait_idle();
    vramGrant = 1'b0;
`else
    access(1'b0, 1'b0, 8'h00);
    check("rd_ff", 24'(cpuDataOut), 24'hFF);
    check("rd_no_cycle", 24'({cpuBusy, vramRequest}), 24'(2'b00));
`endif

    // Reset while a write waits for its grant
    set_address(16'h3000);
    access(1'b0, 1'b1, 8'hEE);
    tick();
    check("rr_busy_before", 24'(cpuBusy), 24'(1));
    reset = 1'b1;
    tick();
    check("rr_busy", 24'(cpuBusy), 24'(0));
    check("rr_req", 24'(vramRequest), 24'(0));
    check("rr_we", 24'(vramWriteEnabled), 24'(0));
    check("rr_addr", 24'(vramAddress), 24'h0000);
    check("rr_wdata", 24'(vramDataWrite), 24'h00);
    check("rr_dataout", 24'(cpuDataOut), 24'h00);
    reset = 1'b0;
    vramGrant = 1'b1;
    repeat (3) tick();
    vramGrant = 1'b0;
    check("rr_mem", 24'(vram_mem[16'h3000]), 24'(8'h00));
    status_read("rr_status", 8'h00);

    check("queue_empty", 24'(exp_q.size()), 24'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
